vga_tile_scanout: RTL and testbench

- Parametrised VGA scan-out engine, successor to the fixed 640x480 1-bit-per-tile controller.
- Generates sync and timing for any mode set by parameters.
- Fetches tile colour data from video memory with a configurable read latency and a configurable bits-per-pixel depth, and registers all outputs aligned to the fetch pipeline.
- Sits between the memory-mapped video buffer and the board VGA DAC pins.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_timing_gen.sv | 60 ++++++
 rtl/vga_tile_scanout.sv | 148 ++++++++++++++
 tb/tb_vga_tile_scanout.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: mode arithmetic, pipeline bundle type and
// helpers shared by the tile scan-out engine.
package vga_pkg;

  localparam int KW = 8;
  localparam int CW = 16;

  function automatic int tot(input int a, b, c, d);
    return a + b + c + d;
  endfunction

  function automatic int wpr_of(input int ha, tile, tpw);
    int cols;
    cols = (ha + tile - 1) / tile;
    return (cols + tpw - 1) / tpw;
  endfunction

  localparam int HT  = tot(640, 16, 96, 48);
  localparam int VT  = tot(480, 10, 2, 33);
  localparam int TPW = 32 / 1;
  localparam int WPR = wpr_of(640, 20, TPW);

  typedef struct packed {
    logic          act;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [KW-1:0] k;
  } pix_t;

  function automatic logic [3:0] expand4(
    input logic [3:0] bits,
    input int         bpp
  );
    logic [3:0] e;
    case (bpp)
      1:       e = {4{bits[0]}};
      2:       e = {2{bits[1:0]}};
      default: e = bits;
    endcase
    return e;
  endfunction

  function automatic logic in_range(
    input int x, lo, hi
  );
    return x >= lo && x <= hi;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: hc/vc raster counters with active,
// raw sync-pulse, first-pixel and last-pixel flags.
// Ports: dclk, clr in; hc, vc, act, hsp, vsp, first, last out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic          dclk,
  input  logic          clr,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          act,
  output logic          hsp,
  output logic          vsp,
  output logic          first,
  output logic          last
);

  localparam int HTOT = tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VTOT = tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS0  = H_ACTIVE + H_FP;
  localparam int VS0  = V_ACTIVE + V_FP;

  logic hend;
  logic vend;

  // hsp/vsp are "inside pulse" flags; polarity is
  // applied only at the output register.
  always_comb begin
    hend  = int'(hc) == HTOT - 1;
    vend  = int'(vc) == VTOT - 1;
    act   = int'(hc) < H_ACTIVE
         && int'(vc) < V_ACTIVE;
    hsp   = in_range(int'(hc), HS0, HS0 + H_SYNC - 1);
    vsp   = in_range(int'(vc), VS0, VS0 + V_SYNC - 1);
    first = hc == '0 && vc == '0;
    last  = hend && vend;
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc <= '0;
      vc <= '0;
    end else if (hend) begin
      hc <= '0;
      vc <= vend ? '0 : vc + CW'(1);
    end else begin
      hc <= hc + CW'(1);
    end
  end

endmodule

// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: parametrised VGA scan-out with tile
// fetch, MEM_LAT-deep alignment line and registered DAC outs.
// Ports: dclk, clr, vdatar/g/b, inv_cfg in;
// vadr, vrd, hsync, vsync, de, frame_start, red/green/blue out.
module vga_tile_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   TILE     = 20,
  parameter int   BPP      = 1,
  parameter int   DATA_W   = 32,
  parameter int   ADDR_W   = 32,
  parameter int   MEM_LAT  = 1
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic [DATA_W-1:0] vdatar,
  input  logic [DATA_W-1:0] vdatag,
  input  logic [DATA_W-1:0] vdatab,
  input  logic [2:0]        inv_cfg,
  output logic [ADDR_W-1:0] vadr,
  output logic              vrd,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int TPWM = DATA_W / BPP;
  localparam int WPRM = wpr_of(H_ACTIVE, TILE, TPWM);

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          act;
  logic          hsp;
  logic          vsp;
  logic          first;
  logic          last;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_tg (
    .dclk  (dclk),
    .clr   (clr),
    .hc    (hc),
    .vc    (vc),
    .act   (act),
    .hsp   (hsp),
    .vsp   (vsp),
    .first (first),
    .last  (last)
  );

  int              col;
  int              row;
  int              word;
  logic [KW-1:0]   kk;
  logic [ADDR_W-1:0] adr;

  always_comb begin
    col  = int'(hc) / TILE;
    row  = int'(vc) / TILE;
    word = col / TPWM;
    kk   = KW'(col % TPWM);
    adr  = ADDR_W'((row * WPRM + word) * 4);
  end

  // p[0] is stage 0; p[MEM_LAT] lines up with the
  // memory word returned for the same pixel.
  pix_t p [MEM_LAT+1];

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i <= MEM_LAT; i++) p[i] <= '0;
      vadr <= '0;
      vrd  <= 1'b0;
    end else begin
      p[0] <= '{act: act, hs: hsp, vs: vsp,
                fs: first, k: kk};
      for (int i = 1; i <= MEM_LAT; i++) p[i] <= p[i-1];
      vrd <= act;
      if (act) vadr <= adr;
    end
  end

  pix_t t;
  assign t = p[MEM_LAT];

  // Tile 0 sits in the word MSBs; shifting left by
  // k fields brings the wanted field to the top.
  function automatic logic [3:0] chan(
    input logic [DATA_W-1:0] w,
    input logic [KW-1:0]     k,
    input logic              iv
  );
    logic [DATA_W-1:0] s;
    logic [3:0]        f;
    s = w << (int'(k) * BPP);
    f = 4'(s[DATA_W-1 -: BPP]);
    return expand4(f, BPP) ^ {4{iv}};
  endfunction

  // The shadow flips at the last counter position of
  // a frame; pixels still in flight are all blanking.
  logic [2:0] inv_q;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      inv_q       <= 3'b000;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      if (last) inv_q <= inv_cfg;
      hsync       <= t.hs ? HS_POL : ~HS_POL;
      vsync       <= t.vs ? VS_POL : ~VS_POL;
      de          <= t.act;
      frame_start <= t.fs;
      red   <= t.act ? chan(vdatar, t.k, inv_q[2]) : '0;
      green <= t.act ? chan(vdatag, t.k, inv_q[1]) : '0;
      blue  <= t.act ? chan(vdatab, t.k, inv_q[0]) : '0;
    end
  end

endmodule

// File: tb/tb_vga_tile_scanout.sv
// tb_vga_tile_scanout: small 26x12 mode, BPP=2, MEM_LAT=2,
// partial last tile; queued expectations vs negedge monitor.
module tb_vga_tile_scanout;

  localparam int L = 4;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       en;
    logic       fs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } orec_t;

  typedef struct packed {
    logic        rd;
    logic [15:0] adr;
  } arec_t;

  localparam orec_t RST  = '{hs: 1'b1, vs: 1'b1, default: '0};
  localparam arec_t ARST = '{rd: 1'b0, adr: 16'h0};

  logic        dclk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  vdatar;
  logic [7:0]  vdatag;
  logic [7:0]  vdatab;
  logic [2:0]  inv_cfg = 3'b000;
  logic [15:0] vadr;
  logic        vrd;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  always #5 dclk = ~dclk;

  vga_tile_scanout #(
    .H_ACTIVE (18), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0),
    .TILE     (4), .BPP (2), .DATA_W (8),
    .ADDR_W   (16), .MEM_LAT (2)
  ) dut (
    .dclk        (dclk),
    .clr         (clr),
    .vdatar      (vdatar),
    .vdatag      (vdatag),
    .vdatab      (vdatab),
    .inv_cfg     (inv_cfg),
    .vadr        (vadr),
    .vrd         (vrd),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  // Video memory: word index = vadr/4, two words per row.
  logic [7:0] mr [4] = '{8'h1B, 8'hBF, 8'hE4, 8'h40};
  logic [7:0] mg [4] = '{8'h00, 8'h3F, 8'hFF, 8'hC0};
  logic [7:0] mb [4] = '{8'h41, 8'h00, 8'h10, 8'hC0};
  logic [7:0] dr [2];
  logic [7:0] dg [2];
  logic [7:0] db [2];

  always @(posedge dclk) begin
    dr[0] <= mr[vadr[3:2]];
    dg[0] <= mg[vadr[3:2]];
    db[0] <= mb[vadr[3:2]];
    dr[1] <= dr[0];
    dg[1] <= dg[0];
    db[1] <= db[0];
  end

  assign vdatar = dr[1];
  assign vdatag = dg[1];
  assign vdatab = db[1];

  // Hand-expanded tile colours [tile row][tile col].
  logic [3:0] tr [2][5] = '{'{4'h0, 4'h5, 4'hA, 4'hF, 4'hA},
                            '{4'hF, 4'hA, 4'h5, 4'h0, 4'h5}};
  logic [3:0] tg [2][5] = '{'{4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
                            '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF}};
  logic [3:0] tb [2][5] = '{'{4'h5, 4'h0, 4'h0, 4'h5, 4'h0},
                            '{4'h0, 4'h5, 4'h0, 4'h0, 4'hF}};

  orec_t       q [$];
  arec_t       aq [$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        in_rst = 1'b1;
  int          h;
  int          v;
  int          k;
  logic [2:0]  inv_cur;
  logic [15:0] last_adr;

  task automatic push_cycle();
    orec_t e;
    arec_t a;
    logic  act;
    int    c;
    int    r;
    act  = h < 18 && v < 8;
    e    = '0;
    e.hs = !(h >= 20 && h <= 22);
    e.vs = !(v >= 9 && v <= 10);
    e.en = act;
    e.fs = h == 0 && v == 0;
    if (act) begin
      c = h / 4;
      r = v / 4;
      e.r = tr[r][c] ^ {4{inv_cur[2]}};
      e.g = tg[r][c] ^ {4{inv_cur[1]}};
      e.b = tb[r][c] ^ {4{inv_cur[0]}};
      last_adr = 16'((r * 2 + c / 4) * 4);
    end
    a.rd  = act;
    a.adr = last_adr;
    q.push_back(e);
    aq.push_back(a);
    if (h == 25 && v == 11) inv_cur = inv_cfg;
    h++;
    if (h == 26) begin
      h = 0;
      v++;
      if (v == 12) v = 0;
    end
    k++;
  endtask

  task automatic release_rst();
    q.delete();
    aq.delete();
    repeat (L) q.push_back(RST);
    aq.push_back(ARST);
    h = 0;
    v = 0;
    k = 0;
    inv_cur  = 3'b000;
    last_adr = 16'h0;
    clr    = 1'b0;
    in_rst = 1'b0;
    push_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge dclk);
      #1;
      push_cycle();
    end
  endtask

  task automatic hold_reset(input int n);
    clr    = 1'b1;
    in_rst = 1'b1;
    q.delete();
    aq.delete();
    repeat (n) begin
      @(posedge dclk);
      #1;
    end
  endtask

  initial forever begin
    orec_t got;
    orec_t exp;
    arec_t agot;
    arec_t aexp;
    @(negedge dclk);
    got = '{hs: hsync, vs: vsync, en: de,
            fs: frame_start, r: red, g: green, b: blue};
    agot = '{rd: vrd, adr: vadr};
    if (in_rst) begin
      exp  = RST;
      aexp = ARST;
    end else begin
      if (q.size() == 0 || aq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL underflow k=%0d got=%h req=queued",
                 k, got);
        continue;
      end
      exp  = q.pop_front();
      aexp = aq.pop_front();
    end
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL pix k=%0d rst=%0b got=%h req=%h",
               k, in_rst, got, exp);
    end
    n_tests++;
    if (agot !== aexp) begin
      n_fail++;
      $display("FAIL adr k=%0d rst=%0b got=%h req=%h",
               k, in_rst, agot, aexp);
    end
  end

  initial begin
    #1 clr = 1'b1;
    repeat (3) begin
      @(posedge dclk);
      #1;
    end
    release_rst();
    run(150);
    inv_cfg = 3'b001;
    run(312);
    inv_cfg = 3'b110;
    run(312);
    hold_reset(5);
    release_rst();
    run(700);
    @(negedge dclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
